mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Sequences every data-memory transaction between the SPARC datapath and the 256-byte RAM, which uses an MFA/MFC handshake.
- Sits directly upstream of the RAM. Drives MFA, opcode, address and store data to it, and captures its read data when MFC is asserted.
- Checks alignment and opcode legality, enforces a handshake timeout, and splits ldd/std into two word transfers.
- Presents the datapath with a Start/Busy/Done interface.

Parameters:
- TIMEOUT, 16, maximum clock cycles allowed in any single wait state before a timeout fault is raised.
- CNT_W, 5, width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- Clk in 1: single clock. All state updates on the rising edge.
- Reset in 1: synchronous, active-high reset.
- Start in 1: request strobe from the datapath. Sampled only in IDLE.
- OpIn in 6: SPARC load/store opcode (see Behaviour).
- AddrIn in 8: byte address.
- StoreData in 32: store word. For std, this is the first (even) word.
- StoreData2 in 32: std second word (address +4).
- Busy out 1: high from the cycle after an accepted Start until Done.
- Done out 1: one-cycle completion pulse, including on fault.
- Fault out 2: 00 ok, 01 misaligned, 10 timeout, 11 illegal opcode. Valid while Done=1 and held until the next accepted Start.
- LoadData out 32: load result, already extended by the RAM. For ldd, the first word.
- LoadData2 out 32: ldd second word.
- MFA out 1: memory function active, to the RAM.
- MemOpcode out 6: opcode presented to the RAM.
- MemAddr out 8: address presented to the RAM.
- MemDataOut out 32: store data presented to the RAM.
- MemDataIn in 32: read data returned by the RAM.
- MFC in 1: memory function complete, from the RAM.

Behaviour:
- Reset (synchronous, dominates everything): state=IDLE, counter=0, Done=0, Busy=0, Fault=00, MFA=0, MemOpcode=0, MemAddr=0, MemDataOut=0, LoadData=0, LoadData2=0.
  - Reset asserted mid-transaction drops MFA at the same edge. No Done is produced.
- All outputs are registered.
- Legal opcodes:
  - Loads: 001001 ldsb, 001010 ldsh, 001000 ld, 000001 ldub, 000010 lduh, 000011 ldd.
  - Stores: 000101 stb, 000110 sth, 000100 st, 000111 std.
  - Any other opcode gives fault 11.
- Alignment rules:
  - Halfword ops require AddrIn[0]=0.
  - Word ops require AddrIn[1:0]=0.
  - ldd/std require AddrIn[2:0]=0.
  - Byte ops are always aligned.
  - Illegal opcode takes priority over misalignment.
- States: IDLE, REQ1, REL1, REQ2, REL2, DONE.
- IDLE:
  - Start=1 and legal: latch operands. MFA=1, MemOpcode, MemAddr=AddrIn and MemDataOut=StoreData take effect at the next edge. Busy=1. Go to REQ1.
  - For ldd/std, MemOpcode is 001000 or 000100 respectively; each half is issued as a plain word transfer.
  - Start=1 and illegal or misaligned: go to DONE with Fault set. MFA never asserts.
  - Start while Busy=1 is ignored.
- REQ1 (MFA=1):
  - MFC=1 sampled: LoadData<=MemDataIn (loads only; stores leave LoadData unchanged), MFA<=0, go to REL1.
  - Otherwise increment the counter.
- REL1 (MFA=0):
  - MFC=0 sampled, single op: go to DONE.
  - MFC=0 sampled, ldd/std: MemAddr<=addr+4, MemDataOut<=StoreData2, MFA<=1, go to REQ2.
  - No wrap is possible, since addr≤248.
- REQ2 / REL2: same as REQ1/REL1, except the captured word goes to LoadData2 and REL2 always exits to DONE.
- Timeout counter:
  - Clears on every state change.
  - If it reaches TIMEOUT in any REQ or REL state: Fault=10, MFA<=0, go to DONE.
  - A load that times out leaves partial data undefined.
- DONE: Done=1 and Busy=0 for exactly one cycle, then return to IDLE. Start in the DONE cycle is ignored.
- Minimum latency, with the RAM answering MFC on the first REQ cycle and dropping it on the first REL cycle: Start edge t, MFA high t+1, MFA low t+2, Done t+3.
  - Double transfers take 2 more cycles (Done at t+5).
- MFC already high on entry to REQ is accepted immediately.
- MFC stuck high in REL causes a timeout.

Test Plan:
- Reset, then st 000100 addr 0x10 data 0xDEADBEEF, then ld 0x10 -> MFA pulses twice, Done with Fault=00, LoadData=0xDEADBEEF.
- ldsb addr 0x10 after the above -> LoadData=0xFFFFFFDE. ldub -> 0x000000DE. With an ideal responder, Done exactly 3 cycles after Start.
- std addr 0x20, StoreData=0x11112222, StoreData2=0x33334444, then ldd 0x20 -> MemAddr 0x20 then 0x24, LoadData=0x11112222, LoadData2=0x33334444, Done at t+5.
- ld addr 0x12, lduh addr 0x11, ldd addr 0x24 -> each: Fault=01, MFA never high, Done at t+1. Opcode 6'b111111 addr 0x01 -> Fault=11.
- Responder holds MFC=0 with TIMEOUT=16 -> MFA drops after 16 REQ cycles, Fault=10, Done pulse. Next legal op completes normally.
- Reset asserted in REQ2 of a std -> MFA=0, Busy=0, Done=0 at the next edge. Start pulsed during Busy is ignored (exactly one Done per accepted Start).

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory transaction sequencer between the SPARC datapath and a 256-byte MFA/MFC RAM.
// Validates opcode/alignment, bounds every handshake wait, and splits ldd/std into two word transfers.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [5:0]  OpIn,
    input  logic [7:0]  AddrIn,
    input  logic [31:0] StoreData,
    input  logic [31:0] StoreData2,
    output logic        Busy,
    output logic        Done,
    output logic [1:0]  Fault,
    output logic [31:0] LoadData,
    output logic [31:0] LoadData2,
    output logic        MFA,
    output logic [5:0]  MemOpcode,
    output logic [7:0]  MemAddr,
    output logic [31:0] MemDataOut,
    input  logic [31:0] MemDataIn,
    input  logic        MFC
);

    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_LD   = 6'b001000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STD  = 6'b000111;

    localparam int N_OPS = 10;
    // Opcode table: entry gi sits at bits [gi*6 +: 6]; loads are entries 0..5.
    localparam logic [N_OPS*6-1:0] OP_TABLE = {OP_STD, OP_ST, OP_STH, OP_STB,
                                               OP_LDD, OP_LDUH, OP_LDUB, OP_LD, OP_LDSH, OP_LDSB};
    localparam logic [N_OPS-1:0]   OP_IS_LOAD = 10'b00_0011_1111;
    // Access size code per entry: 0 byte, 1 halfword, 2 word, 3 doubleword.
    localparam logic [N_OPS*2-1:0] OP_SIZE = {2'd3, 2'd2, 2'd1, 2'd0,
                                              2'd3, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

    localparam logic [1:0] F_OK      = 2'b00;
    localparam logic [1:0] F_ALIGN   = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;
    localparam logic [1:0] F_ILLEGAL = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ1,
        S_REL1,
        S_REQ2,
        S_REL2,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic [1:0]  fault_reg, fault_next;
    logic        mfa_reg, mfa_next;
    logic [5:0]  mem_op_reg, mem_op_next;
    logic [7:0]  mem_addr_reg, mem_addr_next;
    logic [31:0] mem_dout_reg, mem_dout_next;
    logic [31:0] ld_reg, ld_next;
    logic [31:0] ld2_reg, ld2_next;
    logic [31:0] data2_reg, data2_next;
    logic        is_load_reg, is_load_next;
    logic        is_double_reg, is_double_next;

    logic [N_OPS-1:0] op_hit;
    logic        legal_in;
    logic        is_load_in;
    logic [1:0]  size_in;
    logic        misaligned_in;
    logic [5:0]  mem_op_in;
    logic        cnt_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_OPS; gi++) begin : g_op_decode
            assign op_hit[gi] = (OpIn == OP_TABLE[gi*6 +: 6]);
        end
    endgenerate

    always_comb begin
        legal_in   = |op_hit;
        is_load_in = |(op_hit & OP_IS_LOAD);
        size_in    = 2'd0;
        for (int i = 0; i < N_OPS; i++) begin
            if (op_hit[i]) begin
                size_in = OP_SIZE[i*2 +: 2];
            end
        end
        case (size_in)
            2'd1:    misaligned_in = AddrIn[0];
            2'd2:    misaligned_in = |AddrIn[1:0];
            2'd3:    misaligned_in = |AddrIn[2:0];
            default: misaligned_in = 1'b0;
        endcase
        // Each half of a double transfer goes to the RAM as a plain word access.
        if (OpIn == OP_LDD) begin
            mem_op_in = OP_LD;
        end else if (OpIn == OP_STD) begin
            mem_op_in = OP_ST;
        end else begin
            mem_op_in = OpIn;
        end
    end

    assign cnt_hit = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        fault_next     = fault_reg;
        mfa_next       = mfa_reg;
        mem_op_next    = mem_op_reg;
        mem_addr_next  = mem_addr_reg;
        mem_dout_next  = mem_dout_reg;
        ld_next        = ld_reg;
        ld2_next       = ld2_reg;
        data2_next     = data2_reg;
        is_load_next   = is_load_reg;
        is_double_next = is_double_reg;

        case (state_reg)
            S_IDLE: begin
                if (Start) begin
                    cnt_next = '0;
                    if (!legal_in || misaligned_in) begin
                        fault_next = !legal_in ? F_ILLEGAL : F_ALIGN;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = S_DONE;
                    end else begin
                        fault_next     = F_OK;
                        busy_next      = 1'b1;
                        mfa_next       = 1'b1;
                        mem_op_next    = mem_op_in;
                        mem_addr_next  = AddrIn;
                        mem_dout_next  = StoreData;
                        data2_next     = StoreData2;
                        is_load_next   = is_load_in;
                        is_double_next = (size_in == 2'd3);
                        state_next     = S_REQ1;
                    end
                end
            end

            S_REQ1, S_REQ2: begin
                // A completed handshake wins over a timeout expiring on the same edge.
                if (MFC) begin
                    if (is_load_reg && state_reg == S_REQ1) begin
                        ld_next = MemDataIn;
                    end
                    if (is_load_reg && state_reg == S_REQ2) begin
                        ld2_next = MemDataIn;
                    end
                    mfa_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = (state_reg == S_REQ1) ? S_REL1 : S_REL2;
                end else if (cnt_hit) begin
                    fault_next = F_TIMEOUT;
                    mfa_next   = 1'b0;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            S_REL1, S_REL2: begin
                if (!MFC) begin
                    cnt_next = '0;
                    if (state_reg == S_REL1 && is_double_reg) begin
                        mem_addr_next = mem_addr_reg + 8'd4;
                        mem_dout_next = data2_reg;
                        mfa_next      = 1'b1;
                        state_next    = S_REQ2;
                    end else begin
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = S_DONE;
                    end
                end else if (cnt_hit) begin
                    fault_next = F_TIMEOUT;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            S_DONE: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end

            default: begin
                cnt_next   = '0;
                mfa_next   = 1'b0;
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            fault_reg     <= F_OK;
            mfa_reg       <= 1'b0;
            mem_op_reg    <= '0;
            mem_addr_reg  <= '0;
            mem_dout_reg  <= '0;
            ld_reg        <= '0;
            ld2_reg       <= '0;
            data2_reg     <= '0;
            is_load_reg   <= 1'b0;
            is_double_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            fault_reg     <= fault_next;
            mfa_reg       <= mfa_next;
            mem_op_reg    <= mem_op_next;
            mem_addr_reg  <= mem_addr_next;
            mem_dout_reg  <= mem_dout_next;
            ld_reg        <= ld_next;
            ld2_reg       <= ld2_next;
            data2_reg     <= data2_next;
            is_load_reg   <= is_load_next;
            is_double_reg <= is_double_next;
        end
    end

    assign Busy       = busy_reg;
    assign Done       = done_reg;
    assign Fault      = fault_reg;
    assign LoadData   = ld_reg;
    assign LoadData2  = ld2_reg;
    assign MFA        = mfa_reg;
    assign MemOpcode  = mem_op_reg;
    assign MemAddr    = mem_addr_reg;
    assign MemDataOut = mem_dout_reg;

endmodule
